// File: rtl/seq_detect.sv
// Serial pattern detector on the registered dff bit stream, with a saturating match counter.
// Define SEQ_OVERLAP_EN for overlapping detection; by default the window clears after each hit.
module seq_detect #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               d_in,
  input  logic                               d_valid,
  input  logic                               cnt_clr,
  output logic                               match,
  output logic [CNT_W-1:0]                   match_cnt,
  output logic [$clog2(PATTERN_W+1)-1:0]     fill
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PATTERN_W-1:0] window_q, window_d, window_next_s;
  logic [FILL_W-1:0]    fill_q, fill_d, fill_next_s;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_s;

  // Shift-window, fill and hit evaluation for the current sample
  always_comb begin
    window_next_s = {window_q[PATTERN_W-2:0], d_in};
    if (fill_q >= FILL_FULL) begin
      fill_next_s = FILL_FULL;
    end else begin
      fill_next_s = fill_q + FILL_W'(1);
    end
    // The fill guard keeps an all-zero pattern from matching the reset window.
    hit_s    = d_valid && (fill_next_s == FILL_FULL) && (window_next_s == PATTERN);
    window_d = window_q;
    fill_d   = fill_q;
    if (hit_s) begin
`ifdef SEQ_OVERLAP_EN
      window_d = window_next_s;
      fill_d   = FILL_FULL;
`else
      window_d = {PATTERN_W{1'b0}};
      fill_d   = {FILL_W{1'b0}};
`endif
    end else if (d_valid) begin
      window_d = window_next_s;
      fill_d   = fill_next_s;
    end else begin
      window_d = window_q;
      fill_d   = fill_q;
    end
    match_d = hit_s;
  end

  // Match counter: a same-edge hit wins over clear and is counted as the first match
  always_comb begin
    cnt_d = cnt_q;
    if (hit_s && cnt_clr) begin
      cnt_d = CNT_W'(1);
    end else if (hit_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_q <= {PATTERN_W{1'b0}};
      fill_q   <= {FILL_W{1'b0}};
      match_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect.sv
// Directed self-checking bench for seq_detect: default pattern, a 2-bit counter instance
// and an all-zero pattern instance share one stimulus stream.
module tb_seq_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       m_match;
  logic [7:0] m_cnt;
  logic [2:0] m_fill;
  logic       c_match;
  logic [1:0] c_cnt;
  logic [2:0] c_fill;
  logic       z_match;
  logic [7:0] z_cnt;
  logic [2:0] z_fill;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  seq_detect u_main (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .cnt_clr(cnt_clr),
    .match(m_match), .match_cnt(m_cnt), .fill(m_fill)
  );

  seq_detect #(.CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .cnt_clr(cnt_clr),
    .match(c_match), .match_cnt(c_cnt), .fill(c_fill)
  );

  seq_detect #(.PATTERN(4'b0000)) u_zero (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .cnt_clr(cnt_clr),
    .match(z_match), .match_cnt(z_cnt), .fill(z_fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic din, input logic dv, input logic clr);
    @(negedge clk);
    d_in    = din;
    d_valid = dv;
    cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    d_valid = 1'b0;
    cnt_clr = 1'b0;
    rst     = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_match", 32'(m_match), 32'd0);
    chk("reset_cnt",   32'(m_cnt),   32'd0);
    chk("reset_fill",  32'(m_fill),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic hit 1,0,1,1
    step(1'b1, 1'b1, 1'b0);
    chk("basic_fill1", 32'(m_fill), 32'd1);
    chk("basic_nomatch1", 32'(m_match), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("basic_fill2", 32'(m_fill), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    chk("basic_fill3", 32'(m_fill), 32'd3);
    chk("basic_nomatch3", 32'(m_match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("basic_match", 32'(m_match), 32'd1);
    chk("basic_cnt",   32'(m_cnt),   32'd1);
    chk("basic_fill4", 32'(m_fill),  OVL ? 32'd4 : 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("basic_pulse_end", 32'(m_match), 32'd0);
    chk("basic_cnt_hold",  32'(m_cnt),   32'd1);

    // Overlap 1,0,1,1,0,1,1
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovl_match4", 32'(m_match), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovl_nomatch5", 32'(m_match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovl_match7", 32'(m_match), OVL ? 32'd1 : 32'd0);
    chk("ovl_cnt",    32'(m_cnt),   OVL ? 32'd2 : 32'd1);
    chk("ovl_fill",   32'(m_fill),  OVL ? 32'd4 : 32'd3);

    // Gaps: 1,0, five idle cycles with d_in toggling, then 1,1
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'(i), 1'b0, 1'b0);
      chk("gap_match", 32'(m_match), 32'd0);
      chk("gap_fill",  32'(m_fill),  32'd2);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("gap_nomatch3", 32'(m_match), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_match_end", 32'(m_match), 32'd1);
    chk("gap_cnt",       32'(m_cnt),   32'd1);

    // Reset mid-stream: 1,0,1, async reset pulse between edges, then 1
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_fill_pre", 32'(m_fill), OVL ? 32'd4 : 32'd3);
    @(negedge clk);
    d_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("mid_rst_match", 32'(m_match), 32'd0);
    chk("mid_rst_cnt",   32'(m_cnt),   32'd0);
    chk("mid_rst_fill",  32'(m_fill),  32'd0);
    chk("mid_rst_ccnt",  32'(c_cnt),   32'd0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("mid_nomatch", 32'(m_match), 32'd0);
    chk("mid_fill1",   32'(m_fill),  32'd1);

    // Counter saturation on the 2-bit instance
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("sat_match", 32'(c_match), 32'd1);
      chk("sat_cnt",   32'(c_cnt),   (k >= 3) ? 32'd3 : 32'(k));
    end
    chk("sat_main_cnt", 32'(m_cnt), 32'd5);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_hit_match", 32'(c_match), 32'd1);
    chk("clr_hit_cnt",   32'(c_cnt),   32'd1);
    chk("clr_hit_mcnt",  32'(m_cnt),   32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_only_cnt",  32'(c_cnt),   32'd0);
    chk("clr_only_fill", 32'(c_fill),  OVL ? 32'd4 : 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_idle_cnt",  32'(c_cnt),   32'd0);

    // Startup guard with all-zero pattern
    do_reset();
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("zero_nomatch", 32'(z_match), 32'd0);
    end
    chk("zero_fill3", 32'(z_fill), 32'd3);
    step(1'b0, 1'b1, 1'b0);
    chk("zero_match4", 32'(z_match), 32'd1);
    chk("zero_cnt",    32'(z_cnt),   32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("zero_pulse_end", 32'(z_match), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect.md
# seq_detect

Serial bit-pattern detector that sits directly downstream of the team's `dff` stage. It consumes the registered `q` bit stream, one sample per enabled clock. It asserts a one-cycle `match` pulse whenever the last `PATTERN_W` accepted bits equal `PATTERN`, and keeps a saturating count of matches. Detection of overlapping patterns is selected at compile time.

## Interface
Parameters:
- `PATTERN_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default `4'b1011`: target sequence. The MSB is the oldest bit and the LSB is the newest.
- `CNT_W`, default 8: width of `match_cnt`.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-low. `rst`=0 immediately clears all state.
- `d_in`, in, 1: serial data, driven by the `dff` `q` output.
- `d_valid`, in, 1: sample enable. `d_in` is accepted only on edges where `d_valid`=1.
- `cnt_clr`, in, 1: synchronous clear for `match_cnt`.
- `match`, out, 1: registered pulse, one cycle wide, per detected pattern.
- `match_cnt`, out, `CNT_W`: saturating count of matches.
- `fill`, out, `$clog2(PATTERN_W+1)`: number of valid bits in the window, saturating at `PATTERN_W`.

## Operation
- State:
  - `window[PATTERN_W-1:0]`, a shift register.
  - `fill` counter.
  - `match` register.
  - `match_cnt` register.
- Reset values (`rst`=0): `window`=0, `fill`=0, `match`=0, `match_cnt`=0. Reset may occur mid-stream; any partial sequence is discarded.
- Accepted sample (`d_valid`=1):
  - `window_next` = {`window[PATTERN_W-2:0]`, `d_in`}.
  - `fill_next` = min(`fill`+1, `PATTERN_W`).
- Hit condition: `hit` = `d_valid` AND (`fill_next` == `PATTERN_W`) AND (`window_next` == `PATTERN`).
- The `fill` guard is required: fewer than `PATTERN_W` accepted samples never produce a match, even when `PATTERN` is all zeros.
- `match` <= `hit`, so `match` is low on every edge where `hit`=0.
- On a hit, the window and `fill` update as follows:
  - With `SEQ_OVERLAP_EN`: `window` <= `window_next` and `fill` <= `PATTERN_W`.
  - Without `SEQ_OVERLAP_EN`: `window` <= 0 and `fill` <= 0.
- `d_valid`=0: `window` and `fill` hold, and `match` <= 0.
- `match_cnt` update rules:
  - `hit` increments `match_cnt` by 1. At all-ones it holds (saturates, no wrap).
  - `cnt_clr`=1 without `hit`: `match_cnt` <= 0.
  - `cnt_clr`=1 with `hit` on the same edge: `match_cnt` <= 1, because the new match is counted.
  - `cnt_clr` has no effect on `window`, `fill` or `match`.

## Timing
- Latency: `match` rises on the same rising edge that samples the final pattern bit. It is visible for exactly one clock period afterwards.
- Back-to-back matches are possible only with `SEQ_OVERLAP_EN`. The minimum spacing is 1 accepted sample, for patterns whose suffix equals their prefix.
- `match_cnt` changes on the same edge as `match`, so no extra latency.
- `fill` is observable on the edge after each accepted sample.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Asynchronous reset takes effect without a clock edge. Deassertion is sampled by the next rising edge.

## Configuration
- Macro: `SEQ_OVERLAP_EN`.
- Defined: overlapping detection. The window is retained after a hit, so the suffix bits of one match can start the next.
- Undefined (default): non-overlapping detection. The window and `fill` clear after every hit, so a new match needs `PATTERN_W` fresh accepted samples.

## Test plan
Defaults apply in every scenario: `PATTERN`=`1011`, `PATTERN_W`=4, `CNT_W`=8.
- Basic hit: hold `d_valid`=1 and send `1,0,1,1`.
  - `match` is high for one cycle right after the 4th edge.
  - `match_cnt`=1 and `fill`=4 (non-overlap: `fill`=0).
- Overlap: send `1,0,1,1,0,1,1`.
  - With `SEQ_OVERLAP_EN`: matches after samples 4 and 7, `match_cnt`=2.
  - Without it: a single match after sample 4, `match_cnt`=1.
- Gaps: send `1,0`, then `d_valid`=0 for 5 cycles, then `1,1`.
  - `match` stays low during the gap.
  - `match` pulses after the final sample.
  - `fill` holds at 2 during the gap.
- Reset mid-stream: send `1,0,1`, pulse `rst`=0 between clock edges, then send `1`.
  - All outputs go to 0 immediately on reset.
  - No match follows; `fill`=1.
- Counter: with `CNT_W`=2, produce 5 matches.
  - `match_cnt` saturates at 3.
  - `cnt_clr` asserted alone gives 0.
  - `cnt_clr` asserted on the same edge as a hit gives 1.
- Startup guard: with `PATTERN`=`0000`, send 3 zeros then a 4th zero.
  - No `match` on the first 3 samples.
  - `match` pulses on the 4th sample.
